// File: rtl/traffic_cnt_disp.sv
// traffic_cnt_disp: countdown display driver. Converts the remaining phase time
// (x - cnt2) into two BCD digits with a subtract-by-10 engine and scans a
// 3-digit active-low 7-segment display (ones, tens, phase letter).
module traffic_cnt_disp #(
    parameter logic [25:0] CNT_SCAN = 26'd100_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] cnt2,
    input  logic [5:0] x,
    input  logic [2:0] led_sel,
    output logic [2:0] sel,
    output logic [7:0] seg,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       err
);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    localparam logic [7:0] SegBlank = 8'hFF;
    localparam logic [7:0] SegDash  = 8'hBF;

    state_e      state_q, state_d;
    logic [11:0] snap_q, snap_d;
    logic [5:0]  w_q, w_d;
    logic [3:0]  t_q, t_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        err_q, err_d;
    logic [25:0] scan_q, scan_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    // Numeral to active-low segment pattern; out-of-range values show a dash.
    function automatic logic [7:0] enc_num(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SegDash;
        endcase
        return s;
    endfunction

    // Phase letter from the active-low phase select.
    function automatic logic [7:0] enc_phase(input logic [2:0] ph);
        logic [7:0] s;
        case (ph)
            3'b011:  s = 8'hAF;  // r
            3'b101:  s = 8'h91;  // Y
            3'b110:  s = 8'hC2;  // G
            default: s = SegDash;
        endcase
        return s;
    endfunction

    // Segment pattern for the digit addressed by digit select s.
    function automatic logic [7:0] digit_seg(input logic [2:0] s, input logic [3:0] tn,
                                             input logic [3:0] on, input logic er,
                                             input logic [2:0] ph);
        logic [7:0] r;
        case (s)
            3'b110:  r = er ? SegDash : enc_num(on);
            3'b101: begin
                if (er)              r = SegDash;
                else if (tn == 4'd0) r = SegBlank;  // leading-zero blanking
                else                 r = enc_num(tn);
            end
            3'b011:  r = enc_phase(ph);
            default: r = SegBlank;
        endcase
        return r;
    endfunction

    // Conversion FSM: detect input change, then subtract 10 until below 10.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        w_d     = w_q;
        t_d     = t_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if ({x, cnt2} != snap_q) begin
                    snap_d = {x, cnt2};
                    w_d    = x - cnt2;
                    t_d    = 4'd0;
                    if ((x == 6'd0) || (cnt2 >= x)) begin
                        // Invalid input commits immediately; no conversion needed.
                        err_d  = 1'b1;
                        tens_d = 4'd0;
                        ones_d = 4'd0;
                    end else begin
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                if (w_q >= 6'd10) begin
                    w_d = w_q - 6'd10;
                    t_d = t_q + 4'd1;
                end else begin
                    tens_d  = t_q;
                    ones_d  = w_q[3:0];
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan: rotate digit select at terminal count; seg tracks the new digit
    // and uses this edge's committed values so a same-edge commit is shown.
    always_comb begin
        scan_d = scan_q + 26'd1;
        sel_d  = sel_q;
        seg_d  = seg_q;
        if (scan_q == (CNT_SCAN - 26'd1)) begin
            scan_d = 26'd0;
            sel_d  = {sel_q[1:0], sel_q[2]};
            seg_d  = digit_seg(sel_d, tens_d, ones_d, err_d, led_sel);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            snap_q  <= 12'd0;
            w_q     <= 6'd0;
            t_q     <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            err_q   <= 1'b0;
            scan_q  <= 26'd0;
            sel_q   <= 3'b110;
            seg_q   <= SegBlank;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            w_q     <= w_d;
            t_q     <= t_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign sel  = sel_q;
    assign seg  = seg_q;
    assign tens = tens_q;
    assign ones = ones_q;
    assign err  = err_q;

endmodule

// File: tb/tb_traffic_cnt_disp.sv
// tb_traffic_cnt_disp: directed self-checking bench for traffic_cnt_disp.
module tb_traffic_cnt_disp;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [5:0] cnt2;
    logic [5:0] x;
    logic [2:0] led_sel;
    logic [2:0] sel;
    logic [7:0] seg;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    traffic_cnt_disp #(
        .CNT_SCAN(26'd4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .cnt2     (cnt2),
        .x        (x),
        .led_sel  (led_sel),
        .sel      (sel),
        .seg      (seg),
        .tens     (tens),
        .ones     (ones),
        .err      (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; returns at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Wait for a rotation edge that moves sel into target (bounded).
    task automatic wait_sel(input string tag, input logic [2:0] target);
        logic [2:0] prev;
        bit         hit;
        hit  = 1'b0;
        prev = sel;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ((sel == target) && (prev != target)) begin
                hit = 1'b1;
                break;
            end
            prev = sel;
        end
        if (!hit) check(tag, {13'd0, sel}, {13'd0, target});
    endtask

    initial begin
        sys_rst_n = 1'b0;
        x         = 6'd0;
        cnt2      = 6'd0;
        led_sel   = 3'b011;
        step(3);
        check("rst_sel", {13'd0, sel}, 16'h0006);
        check("rst_seg", {8'd0, seg}, 16'h00FF);
        check("rst_tens", {12'd0, tens}, 16'h0000);
        check("rst_ones", {12'd0, ones}, 16'h0000);
        check("rst_err", {15'd0, err}, 16'h0000);

        // First rotation after exactly CNT_SCAN edges.
        sys_rst_n = 1'b1;
        step(3);
        check("pre_rot_sel", {13'd0, sel}, 16'h0006);
        check("pre_rot_seg", {8'd0, seg}, 16'h00FF);
        step(1);
        check("rot1_sel", {13'd0, sel}, 16'h0005);
        check("rot1_seg", {8'd0, seg}, 16'h00FF);

        // x=15, cnt2=0 -> 1,5 at E+2.
        x = 6'd15; cnt2 = 6'd0;
        step(2);
        check("r15_e1_tens", {12'd0, tens}, 16'h0000);
        step(1);
        check("r15_tens", {12'd0, tens}, 16'h0001);
        check("r15_ones", {12'd0, ones}, 16'h0005);
        check("r15_err", {15'd0, err}, 16'h0000);
        wait_sel("r15_w101", 3'b101);
        check("r15_seg_d1", {8'd0, seg}, 16'h00F9);
        wait_sel("r15_w110", 3'b110);
        check("r15_seg_d0", {8'd0, seg}, 16'h0092);

        // x=10, cnt2=7 -> 0,3 at E+1, tens blanked.
        x = 6'd10; cnt2 = 6'd7;
        step(1);
        check("r3_e0_ones", {12'd0, ones}, 16'h0005);
        step(1);
        check("r3_ones", {12'd0, ones}, 16'h0003);
        check("r3_tens", {12'd0, tens}, 16'h0000);
        wait_sel("r3_w101", 3'b101);
        check("r3_seg_d1", {8'd0, seg}, 16'h00FF);
        wait_sel("r3_w110", 3'b110);
        check("r3_seg_d0", {8'd0, seg}, 16'h00B0);

        // x=63 -> commit at exactly E+7; cnt2 change at E+3 recaptured after.
        x = 6'd63; cnt2 = 6'd0;
        step(3);                      // through E+2
        cnt2 = 6'd1;
        step(4);                      // through E+6
        check("r63_e6_ones", {12'd0, ones}, 16'h0003);
        check("r63_e6_tens", {12'd0, tens}, 16'h0000);
        step(1);                      // E+7
        check("r63_tens", {12'd0, tens}, 16'h0006);
        check("r63_ones", {12'd0, ones}, 16'h0003);
        step(7);                      // E+14: recapture at E+8 still converting
        check("r62_e14_ones", {12'd0, ones}, 16'h0003);
        step(1);                      // E+15
        check("r62_ones", {12'd0, ones}, 16'h0002);
        check("r62_tens", {12'd0, tens}, 16'h0006);

        // Invalid inputs commit on the capture edge.
        x = 6'd5; cnt2 = 6'd5;
        step(1);
        check("inv_err", {15'd0, err}, 16'h0001);
        check("inv_tens", {12'd0, tens}, 16'h0000);
        check("inv_ones", {12'd0, ones}, 16'h0000);
        wait_sel("inv_w101", 3'b101);
        check("inv_seg_d1", {8'd0, seg}, 16'h00BF);
        wait_sel("inv_w110", 3'b110);
        check("inv_seg_d0", {8'd0, seg}, 16'h00BF);
        x = 6'd0; cnt2 = 6'd0;
        step(2);
        check("inv0_err", {15'd0, err}, 16'h0001);
        x = 6'd15; cnt2 = 6'd0;
        step(3);
        check("clr_err", {15'd0, err}, 16'h0000);
        check("clr_ones", {12'd0, ones}, 16'h0005);

        // Phase letters on digit2.
        led_sel = 3'b011;
        wait_sel("ph_r_w", 3'b011);
        check("ph_r", {8'd0, seg}, 16'h00AF);
        led_sel = 3'b101;
        wait_sel("ph_y_w", 3'b011);
        check("ph_y", {8'd0, seg}, 16'h0091);
        led_sel = 3'b110;
        wait_sel("ph_g_w", 3'b011);
        check("ph_g", {8'd0, seg}, 16'h00C2);
        led_sel = 3'b111;
        wait_sel("ph_bad_w", 3'b011);
        check("ph_bad", {8'd0, seg}, 16'h00BF);

        // Reset mid-conversion, then recapture the same inputs.
        x = 6'd63; cnt2 = 6'd0;
        step(2);                      // through E+1
        sys_rst_n = 1'b0;
        step(1);                      // E+2 sees reset
        check("mrst_tens", {12'd0, tens}, 16'h0000);
        check("mrst_ones", {12'd0, ones}, 16'h0000);
        check("mrst_sel", {13'd0, sel}, 16'h0006);
        check("mrst_seg", {8'd0, seg}, 16'h00FF);
        sys_rst_n = 1'b1;
        step(7);                      // E' + 6
        check("mrst_e6_tens", {12'd0, tens}, 16'h0000);
        step(1);                      // E' + 7
        check("mrst_tens2", {12'd0, tens}, 16'h0006);
        check("mrst_ones2", {12'd0, ones}, 16'h0003);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
